// File: rtl/monitor_verdict_serializer.sv
`default_nettype none
// ============================================================================
// Module      : monitor_verdict_serializer
// Description : Captures every enabled cycle with at least one active monitor
//               output stream into a frame FIFO. Each frame is replayed as one
//               record per active stream, in ascending stream index, on a
//               valid/ready interface. Frames that arrive while the FIFO is
//               full are dropped. A dropped frame sets the sticky `overflow`
//               flag and increments the saturating `drop_count`.
// Ports       : clk, rst (async, active-high), en (global enable)
//               out_data/out_aktv    - monitor streams and per-stream strobes
//               m_valid/m_ready      - record handshake
//               m_index/m_value      - stream index and value of the record
//               m_timestamp          - capture timestamp of the record's frame
//               m_last               - last record of its frame
//               overflow/drop_count  - dropped-frame reporting
// Config      : VERDICT_TIMESTAMP_EN - when defined, a free-running timestamp
//               counter (advancing on enabled edges) is stored with each
//               frame. When undefined, the counter is absent and m_timestamp
//               is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module monitor_verdict_serializer #(
    parameter int NUM_OUTPUTS = 10,
    parameter int DATA_W      = 64,
    parameter int FIFO_DEPTH  = 16,
    parameter int TS_W        = 32,
    parameter int IDX_W       = $clog2(NUM_OUTPUTS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [NUM_OUTPUTS*DATA_W-1:0] out_data,
    input  logic [NUM_OUTPUTS-1:0]        out_aktv,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [IDX_W-1:0]              m_index,
    output logic [DATA_W-1:0]             m_value,
    output logic [TS_W-1:0]               m_timestamp,
    output logic                          m_last,
    output logic                          overflow,
    output logic [15:0]                   drop_count
);

    localparam int                     c_PTR_W    = $clog2(FIFO_DEPTH);
    localparam logic [c_PTR_W:0]       c_DEPTH    = (c_PTR_W+1)'(FIFO_DEPTH);
    localparam logic [c_PTR_W:0]       c_CNT_ONE  = (c_PTR_W+1)'(1);
    localparam logic [c_PTR_W-1:0]     c_PTR_ONE  = c_PTR_W'(1);
    localparam logic [NUM_OUTPUTS-1:0] c_MASK_ONE = NUM_OUTPUTS'(1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_EMIT = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    function automatic logic [IDX_W-1:0] f_lowest(input logic [NUM_OUTPUTS-1:0] mask);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = NUM_OUTPUTS - 1; i >= 0; i--) begin
            if (mask[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    function automatic logic f_single(input logic [NUM_OUTPUTS-1:0] mask);
        return (mask != '0) && ((mask & (mask - c_MASK_ONE)) == '0);
    endfunction

    function automatic logic [DATA_W-1:0] f_pick(input logic [NUM_OUTPUTS*DATA_W-1:0] data,
                                                 input logic [IDX_W-1:0]              idx);
        logic [DATA_W-1:0] val;
        val = '0;
        for (int i = 0; i < NUM_OUTPUTS; i++) begin
            if (IDX_W'(i) == idx) val = data[i*DATA_W +: DATA_W];
        end
        return val;
    endfunction

    // ------------------------------------------------------------------
    // Storage and state
    // ------------------------------------------------------------------
    logic [NUM_OUTPUTS-1:0]        r_mem_mask [FIFO_DEPTH];
    logic [NUM_OUTPUTS*DATA_W-1:0] r_mem_data [FIFO_DEPTH];
    logic [c_PTR_W-1:0]            r_wr_ptr;
    logic [c_PTR_W-1:0]            r_rd_ptr;
    logic [c_PTR_W:0]              r_count;

    state_t                        r_state;
    logic [NUM_OUTPUTS-1:0]        r_mask;      // streams of the head frame not yet sent
    logic                          r_m_valid;
    logic [IDX_W-1:0]              r_m_index;
    logic [DATA_W-1:0]             r_m_value;
    logic                          r_m_last;
    logic                          r_overflow;
    logic [15:0]                   r_drop_count;

`ifdef VERDICT_TIMESTAMP_EN
    logic [TS_W-1:0]               r_mem_ts [FIFO_DEPTH];
    logic [TS_W-1:0]               r_ts;
    logic [TS_W-1:0]               r_m_timestamp;
    logic [TS_W-1:0]               w_load_ts;
`endif

    logic                          w_xfer;
    logic                          w_pop;
    logic                          w_full;
    logic                          w_push_req;
    logic                          w_push;
    logic                          w_drop;
    logic                          w_idle_load;
    logic                          w_reload;
    logic                          w_load;
    logic                          w_advance;
    logic [c_PTR_W-1:0]            w_rd_next;
    logic [NUM_OUTPUTS-1:0]        w_load_mask;
    logic [NUM_OUTPUTS*DATA_W-1:0] w_load_data;
    logic [NUM_OUTPUTS-1:0]        w_sel_mask;
    logic [NUM_OUTPUTS*DATA_W-1:0] w_sel_data;
    logic [IDX_W-1:0]              w_sel_idx;

    // ------------------------------------------------------------------
    // Handshake, push/pop and drop decisions
    // ------------------------------------------------------------------
    always_comb begin
        w_xfer      = en & r_m_valid & m_ready;
        w_pop       = w_xfer & r_m_last;
        w_full      = (r_count == c_DEPTH);
        w_push_req  = en & (|out_aktv);
        // A full FIFO still accepts the frame when the head leaves on this edge.
        w_push      = w_push_req & (~w_full | w_pop);
        w_drop      = w_push_req & w_full & ~w_pop;
        w_idle_load = (r_state == S_IDLE) & en & (r_count != '0);
        // After a pop, the next frame is either the second stored entry or,
        // with a single stored frame, the frame being captured right now.
        w_reload    = w_pop & ((r_count > c_CNT_ONE) | w_push);
        w_load      = w_idle_load | w_reload;
        w_advance   = w_xfer & ~r_m_last;
        w_rd_next   = r_rd_ptr + c_PTR_ONE;
    end

    // ------------------------------------------------------------------
    // Source of the next presented record
    // ------------------------------------------------------------------
    always_comb begin
        w_load_mask = r_mem_mask[r_rd_ptr];
        w_load_data = r_mem_data[r_rd_ptr];
`ifdef VERDICT_TIMESTAMP_EN
        w_load_ts   = r_mem_ts[r_rd_ptr];
`endif
        if (r_state == S_EMIT) begin
            if (r_count > c_CNT_ONE) begin
                w_load_mask = r_mem_mask[w_rd_next];
                w_load_data = r_mem_data[w_rd_next];
`ifdef VERDICT_TIMESTAMP_EN
                w_load_ts   = r_mem_ts[w_rd_next];
`endif
            end else begin
                w_load_mask = out_aktv;
                w_load_data = out_data;
`ifdef VERDICT_TIMESTAMP_EN
                w_load_ts   = r_ts;
`endif
            end
        end

        // Within a frame, clearing the lowest set bit retires the record just sent.
        w_sel_mask = w_load ? w_load_mask : (r_mask & (r_mask - c_MASK_ONE));
        w_sel_data = w_load ? w_load_data : r_mem_data[r_rd_ptr];
        w_sel_idx  = f_lowest(w_sel_mask);
    end

    // ------------------------------------------------------------------
    // Frame FIFO payload (no reset needed; validity tracked by r_count)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_mask[r_wr_ptr] <= out_aktv;
            r_mem_data[r_wr_ptr] <= out_data;
`ifdef VERDICT_TIMESTAMP_EN
            r_mem_ts[r_wr_ptr]   <= r_ts;
`endif
        end
    end

    // ------------------------------------------------------------------
    // FIFO pointers, drop accounting and emitter FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_state      <= S_IDLE;
            r_mask       <= '0;
            r_m_valid    <= 1'b0;
            r_m_index    <= '0;
            r_m_value    <= '0;
            r_m_last     <= 1'b0;
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_pop)  r_rd_ptr <= w_rd_next;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase

            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_count != 16'hFFFF) r_drop_count <= r_drop_count + 16'd1;
            end

            if (w_load | w_advance) begin
                r_state   <= S_EMIT;
                r_m_valid <= 1'b1;
                r_mask    <= w_sel_mask;
                r_m_index <= w_sel_idx;
                r_m_value <= f_pick(w_sel_data, w_sel_idx);
                r_m_last  <= f_single(w_sel_mask);
            end else if (w_pop) begin
                r_state   <= S_IDLE;
                r_m_valid <= 1'b0;
            end
        end
    end

`ifdef VERDICT_TIMESTAMP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ts          <= '0;
            r_m_timestamp <= '0;
        end else begin
            if (en)     r_ts          <= r_ts + TS_W'(1);
            if (w_load) r_m_timestamp <= w_load_ts;
        end
    end
    assign m_timestamp = r_m_timestamp;
`else
    assign m_timestamp = '0;
`endif

    assign m_valid    = r_m_valid;
    assign m_index    = r_m_index;
    assign m_value    = r_m_value;
    assign m_last     = r_m_last;
    assign overflow   = r_overflow;
    assign drop_count = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_monitor_verdict_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_monitor_verdict_serializer
// Description : Self-checking bench for monitor_verdict_serializer. A frame
//               queue model predicts the presented record, drops and the
//               valid timing every cycle; directed phases pin literal values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_monitor_verdict_serializer;

    localparam int N  = 10;
    localparam int DW = 64;
    localparam int D  = 16;
    localparam int TW = 32;
    localparam int IW = 4;
`ifdef VERDICT_TIMESTAMP_EN
    localparam bit TS_ON = 1'b1;
`else
    localparam bit TS_ON = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            en  = 1'b0;
    logic [N*DW-1:0] out_data = '0;
    logic [N-1:0]    out_aktv = '0;
    logic            m_ready  = 1'b0;
    logic            m_valid;
    logic [IW-1:0]   m_index;
    logic [DW-1:0]   m_value;
    logic [TW-1:0]   m_timestamp;
    logic            m_last;
    logic            overflow;
    logic [15:0]     drop_count;

    monitor_verdict_serializer #(
        .NUM_OUTPUTS(N), .DATA_W(DW), .FIFO_DEPTH(D), .TS_W(TW), .IDX_W(IW)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .out_data(out_data), .out_aktv(out_aktv),
        .m_valid(m_valid), .m_ready(m_ready), .m_index(m_index), .m_value(m_value),
        .m_timestamp(m_timestamp), .m_last(m_last), .overflow(overflow),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]    mask;
        logic [N*DW-1:0] data;
        logic [TW-1:0]   ts;
        logic [N-1:0]    rem;
    } frame_t;

    typedef struct packed {
        logic [IW-1:0] idx;
        logic [DW-1:0] val;
        logic          last;
        logic [TW-1:0] ts;
    } rec_t;

    frame_t      q[$];
    rec_t        log_q[$];
    int          checks;
    int          errors;
    logic        exp_valid;
    logic        exp_ovf;
    int          exp_drops;
    logic [TW-1:0] mts;
    int          free_cyc;
    logic        chk_en;

    // model-process scratch
    bit          m_before;
    int          m_k;
    frame_t      m_f;
    frame_t      c_f;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lowest(input logic [N-1:0] m);
        for (int i = 0; i < N; i++) if (m[i]) return i;
        return 0;
    endfunction

    function automatic logic [N*DW-1:0] rnd_data();
        logic [N*DW-1:0] d;
        for (int i = 0; i < N*DW/32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic model_reset();
        q.delete();
        exp_valid = 1'b0;
        exp_ovf   = 1'b0;
        exp_drops = 0;
        mts       = '0;
        free_cyc  = 0;
    endtask

    task automatic compare();
        int k;
        check("valid", m_valid, exp_valid);
        check("overflow", overflow, exp_ovf);
        check("drop_count", drop_count, 64'(exp_drops));
        if (exp_valid && q.size() > 0) begin
            c_f = q[0];
            k = lowest(c_f.rem);
            check("index", m_index, 64'(k));
            check("value", m_value, c_f.data[k*DW +: DW]);
            check("last", m_last, 64'($countones(c_f.rem) == 1));
            check("timestamp", m_timestamp, TS_ON ? 64'(c_f.ts) : 64'd0);
        end
    endtask

    // Frame-queue model: a frame lives in the FIFO from capture until its
    // last record is accepted; records leave lowest index first.
    always @(posedge clk) begin
        if (!rst) begin
            free_cyc++;
            if (en) begin
                if (m_valid && m_ready)
                    log_q.push_back('{m_index, m_value, m_last, m_timestamp});
                m_before = (q.size() > 0);
                if (exp_valid && m_ready && q.size() > 0) begin
                    m_f = q[0];
                    m_k = lowest(m_f.rem);
                    m_f.rem[m_k] = 1'b0;
                    if (m_f.rem == '0) void'(q.pop_front());
                    else q[0] = m_f;
                end
                if (|out_aktv) begin
                    if (q.size() < D) begin
                        m_f.mask = out_aktv;
                        m_f.data = out_data;
                        m_f.ts   = mts;
                        m_f.rem  = out_aktv;
                        q.push_back(m_f);
                    end else begin
                        exp_ovf = 1'b1;
                        if (exp_drops < 65535) exp_drops++;
                    end
                end
                exp_valid = m_before && (q.size() > 0);
                mts = mts + 1;
            end
            #1;
            if (chk_en && !rst) compare();
        end
    end

    logic          seen;
    logic [TW-1:0] ts_a;
    int            ts_exp5;

    initial begin
        checks = 0;
        errors = 0;
        chk_en = 1'b0;
        model_reset();

        // Reset state
        #2 rst = 1'b1;
        #1;
        check("rst_valid", m_valid, 0);
        check("rst_overflow", overflow, 0);
        check("rst_drops", drop_count, 0);
        check("rst_index", m_index, 0);
        check("rst_value", m_value, 0);
        check("rst_last", m_last, 0);
        check("rst_ts", m_timestamp, 0);
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b1;
        model_reset();
        chk_en = 1'b1;

        // 1: idle streams never produce records
        seen = 1'b0;
        repeat (50) begin
            m_ready  = 1'($urandom_range(0, 1));
            out_data = rnd_data();
            @(negedge clk);
            if (m_valid) seen = 1'b1;
        end
        check("t1_never_valid", seen, 0);
        check("t1_overflow", overflow, 0);

        // 2: one frame with streams 0 and 2, captured at edge 51 (ts 50)
        log_q.delete();
        m_ready  = 1'b1;
        out_data = rnd_data();
        out_data[0 +: DW]    = 64'd7;
        out_data[2*DW +: DW] = 64'hFFFF_FFFF_FFFF_FFFD;
        out_aktv = 10'b00_0000_0101;
        @(negedge clk);
        out_aktv = '0;
        repeat (6) @(negedge clk);
        check("t2_count", 64'(log_q.size()), 2);
        if (log_q.size() == 2) begin
            check("t2_idx0", log_q[0].idx, 0);
            check("t2_val0", log_q[0].val, 64'd7);
            check("t2_last0", log_q[0].last, 0);
            check("t2_ts0", log_q[0].ts, TS_ON ? 64'd50 : 64'd0);
            check("t2_idx1", log_q[1].idx, 2);
            check("t2_val1", log_q[1].val, 64'hFFFF_FFFF_FFFF_FFFD);
            check("t2_last1", log_q[1].last, 1);
            check("t2_ts1", log_q[1].ts, TS_ON ? 64'd50 : 64'd0);
        end

        // 3: 17 frames with the sink stalled; the 17th is dropped
        m_ready = 1'b0;
        log_q.delete();
        for (int i = 0; i < 17; i++) begin
            out_aktv = N'(1) << (i % N);
            out_data = rnd_data();
            @(negedge clk);
        end
        out_aktv = '0;
        repeat (2) @(negedge clk);
        check("t3_overflow", overflow, 1);
        check("t3_drops", drop_count, 1);
        m_ready = 1'b1;
        repeat (30) @(negedge clk);
        check("t3_count", 64'(log_q.size()), 16);
        for (int i = 0; i < 16 && i < log_q.size(); i++) begin
            check("t3_order", log_q[i].idx, 64'(i % N));
            check("t3_last", log_q[i].last, 1);
        end

        // 4: capture on the same edge as the last record of the only frame
        log_q.delete();
        ts_a = mts;
        out_data = rnd_data();
        out_aktv = 10'b00_0010_0011;
        @(negedge clk);
        out_aktv = '0;
        repeat (3) @(negedge clk);
        out_data = rnd_data();
        out_aktv = 10'b10_0100_0000;
        @(negedge clk);
        out_aktv = '0;
        check("t4_no_bubble", m_valid, 1);
        check("t4_index", m_index, 6);
        check("t4_last", m_last, 0);
        check("t4_ts", m_timestamp, TS_ON ? 64'(ts_a + 4) : 64'd0);
        repeat (2) @(negedge clk);
        check("t4_count", 64'(log_q.size()), 5);
        check("t4_drained", m_valid, 0);

        // 5: enable low for five cycles in the middle of a frame
        log_q.delete();
        out_data = rnd_data();
        out_aktv = 10'b00_0101_1010;
        @(negedge clk);
        out_aktv = '0;
        repeat (2) @(negedge clk);
        en = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("t5_hold_valid", m_valid, 1);
            check("t5_hold_index", m_index, 3);
            check("t5_no_xfer", 64'(log_q.size()), 1);
        end
        en = 1'b1;
        repeat (6) @(negedge clk);
        check("t5_count", 64'(log_q.size()), 4);
        ts_exp5 = free_cyc - 5;
        out_aktv = 10'b00_0000_0001;
        @(negedge clk);
        out_aktv = '0;
        @(negedge clk);
        check("t5_valid", m_valid, 1);
        check("t5_ts_offset", m_timestamp, TS_ON ? 64'(ts_exp5) : 64'd0);
        repeat (3) @(negedge clk);

        // 6: asynchronous reset in the middle of a frame
        out_data = rnd_data();
        out_aktv = 10'b11_1100_0000;
        @(negedge clk);
        out_aktv = '0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        model_reset();
        #1;
        check("t6_valid", m_valid, 0);
        check("t6_overflow", overflow, 0);
        check("t6_drops", drop_count, 0);
        check("t6_index", m_index, 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        out_aktv = 10'b00_0000_0010;
        @(negedge clk);
        out_aktv = '0;
        @(negedge clk);
        check("t6_restart_valid", m_valid, 1);
        check("t6_restart_index", m_index, 1);
        check("t6_restart_ts", m_timestamp, 0);

        // Random traffic with alternating fast and slow sinks
        for (int i = 0; i < 3000; i++) begin
            en       = ($urandom_range(0, 15) != 0);
            out_aktv = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
            out_data = rnd_data();
            if ((i / 500) % 2 == 1) m_ready = ($urandom_range(0, 3) == 0);
            else                    m_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
        end
        en       = 1'b1;
        out_aktv = '0;
        m_ready  = 1'b1;
        repeat (200) @(negedge clk);
        check("drain_valid", m_valid, 0);
        check("drain_model_empty", 64'(q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
